// File: rtl/risc16_dmem_responder_if.sv
// Load/store channel between a RISC16 core (master) and its data-memory responder (slave).
// Both channels use valid/ready: a transfer happens on a rising edge where valid and ready are both high.
// Once valid is raised, its payload stays stable until that edge.
interface risc16_dmem_responder_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_we;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_we
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_we
  );
endinterface

// File: rtl/risc16_dmem_responder.sv
// Data-memory responder: a 2**ADDR_W x DATA_W RAM serving one access at a time with programmable latency.
// State is exported on state_dbg (0 = IDLE, 1 = WAIT, 2 = RESP).
module risc16_dmem_responder #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 16,
  parameter int LATENCY = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  risc16_dmem_responder_if.slave   bus,
  output logic [15:0]              access_count,
  output logic [1:0]               state_dbg
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [3:0] CNT_INIT = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

  if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
    $fatal(1, "risc16_dmem_responder: LATENCY must be in 1..15");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [3:0]          cnt_q;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                rsp_we_q;
  logic [15:0]         access_count_q;

  logic [DATA_W-1:0]   mem [DEPTH] = '{default: '0};

  logic                accept;
  logic                enter_resp;
  logic                acc_we;
  logic [ADDR_W-1:0]   acc_addr;
  logic [DATA_W-1:0]   acc_wdata;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (bus.req_valid) state_d = (LATENCY == 1) ? RESP : WAIT;
      WAIT: if (cnt_q == 4'd0) state_d = RESP;
      RESP: if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    bus.req_ready = (state_q == IDLE);
    bus.rsp_valid = (state_q == RESP);
    bus.rsp_rdata = rdata_q;
    bus.rsp_we    = rsp_we_q;
    access_count  = access_count_q;
    state_dbg     = state_q;
  end

  // With LATENCY==1 the access happens on the accepting edge, so take fields straight from the bus.
  assign accept     = (state_q == IDLE) && bus.req_valid;
  assign enter_resp = rst_n && (state_q != RESP) && (state_d == RESP);
  assign acc_we     = (state_q == IDLE) ? bus.req_we    : we_q;
  assign acc_addr   = (state_q == IDLE) ? bus.req_addr  : addr_q;
  assign acc_wdata  = (state_q == IDLE) ? bus.req_wdata : wdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q          <= 4'd0;
      we_q           <= 1'b0;
      addr_q         <= '0;
      wdata_q        <= '0;
      rdata_q        <= '0;
      rsp_we_q       <= 1'b0;
      access_count_q <= 16'd0;
    end else begin
      if (accept) begin
        we_q    <= bus.req_we;
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
        cnt_q   <= CNT_INIT;
      end else if (state_q == WAIT && cnt_q != 4'd0) begin
        cnt_q <= cnt_q - 4'd1;
      end
      if (enter_resp) begin
        rdata_q  <= acc_we ? acc_wdata : mem[acc_addr];
        rsp_we_q <= acc_we;
      end
      if (state_q == RESP && bus.rsp_ready) begin
        access_count_q <= access_count_q + 16'd1;
      end
    end
  end

  // RAM contents survive reset; a store commits only on the edge that enters RESP.
  always_ff @(posedge clk) begin
    if (enter_resp && acc_we) mem[acc_addr] <= acc_wdata;
  end

endmodule

// File: tb/tb_risc16_dmem_responder.sv
// Bench for risc16_dmem_responder: four builds (LATENCY 2, 1, 15, 4) share one stimulus bus selected by sel.
// Expected responses are queued at issue time and checked by an independent monitor.
module tb_risc16_dmem_responder;

  logic        clk;
  logic        rst_n;
  int          sel;
  logic        req_valid;
  logic        req_we;
  logic [7:0]  req_addr;
  logic [15:0] req_wdata;
  logic        rsp_ready;

  logic        o_req_ready [4];
  logic        o_rsp_valid [4];
  logic [15:0] o_rsp_rdata [4];
  logic        o_rsp_we    [4];
  logic [15:0] o_count     [4];
  logic [1:0]  o_state     [4];

  logic        m_req_ready, m_rsp_valid, m_rsp_we;
  logic [15:0] m_rsp_rdata, m_count;
  logic [1:0]  m_state;

  logic [16:0] exp_q[$];
  int          tests_run;
  int          tests_failed;

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar i = 0; i < 4; i++) begin : g_dut
    localparam int LAT = (i == 0) ? 2 : (i == 1) ? 1 : (i == 2) ? 15 : 4;
    risc16_dmem_responder_if #(.ADDR_W(8), .DATA_W(16)) bus ();
    assign bus.req_valid = req_valid && (sel == i);
    assign bus.req_we    = req_we;
    assign bus.req_addr  = req_addr;
    assign bus.req_wdata = req_wdata;
    assign bus.rsp_ready = rsp_ready && (sel == i);
    assign o_req_ready[i] = bus.req_ready;
    assign o_rsp_valid[i] = bus.rsp_valid;
    assign o_rsp_rdata[i] = bus.rsp_rdata;
    assign o_rsp_we[i]    = bus.rsp_we;

    risc16_dmem_responder #(.ADDR_W(8), .DATA_W(16), .LATENCY(LAT)) u_dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .bus          (bus.slave),
      .access_count (o_count[i]),
      .state_dbg    (o_state[i])
    );
  end

  assign m_req_ready = o_req_ready[sel];
  assign m_rsp_valid = o_rsp_valid[sel];
  assign m_rsp_rdata = o_rsp_rdata[sel];
  assign m_rsp_we    = o_rsp_we[sel];
  assign m_count     = o_count[sel];
  assign m_state     = o_state[sel];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: a response handshake completes on the next rising edge.
  always @(negedge clk) begin
    if (rst_n && m_rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("FAIL unexpected_rsp: got we=%0b rdata=0x%0h, expected no response", m_rsp_we, m_rsp_rdata);
      end else begin
        check("rsp_we_rdata", {15'd0, m_rsp_we, m_rsp_rdata}, {15'd0, exp_q.pop_front()});
      end
    end
  end

  // Driver: called just after a rising edge. Returns at the falling edge where rsp_valid is first seen;
  // lat counts rising edges from the accepting edge (which counts as 1). Optional req_valid pulse at lat==pulse_at.
  task automatic issue(input logic we, input logic [7:0] addr, input logic [15:0] wdata,
                       input logic [15:0] exp_rdata, input int pulse_at, output int lat);
    exp_q.push_back({we, exp_rdata});
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_valid = 1'b1;
    @(negedge clk);
    check("req_ready_before_accept", {31'd0, m_req_ready}, 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 1;
    forever begin
      @(negedge clk);
      if (m_rsp_valid) break;
      if (lat >= 40) begin
        tests_run++;
        tests_failed++;
        $display("FAIL rsp_timeout: got no rsp_valid after %0d edges, expected a response", lat);
        break;
      end
      @(posedge clk);
      #1 lat++;
      req_valid = (lat == pulse_at);
    end
    req_valid = 1'b0;
  endtask

  // Completes a response with rsp_ready already high, returning just after the handshake edge.
  task automatic finish_rsp();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int lat;
    logic [15:0] held;
    tests_run    = 0;
    tests_failed = 0;
    sel       = 0;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = 8'h00;
    req_wdata = 16'h0000;
    rsp_ready = 1'b1;

    // Reset state
    #12;
    check("reset_req_ready", {31'd0, m_req_ready}, 32'd1);
    check("reset_rsp_valid", {31'd0, m_rsp_valid}, 32'd0);
    check("reset_rsp_rdata", {16'd0, m_rsp_rdata}, 32'd0);
    check("reset_rsp_we", {31'd0, m_rsp_we}, 32'd0);
    check("reset_count", {16'd0, m_count}, 32'd0);
    check("reset_state", {30'd0, m_state}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    // LATENCY=2: load from untouched RAM, then store/load round trip
    issue(1'b0, 8'h05, 16'h0000, 16'h0000, 0, lat);
    check("lat2_load_latency", lat, 32'd2);
    finish_rsp();
    issue(1'b1, 8'h10, 16'hBEEF, 16'hBEEF, 0, lat);
    check("lat2_store_latency", lat, 32'd2);
    finish_rsp();
    issue(1'b0, 8'h10, 16'h0000, 16'hBEEF, 0, lat);
    finish_rsp();
    @(negedge clk);
    check("lat2_count_after_3", {16'd0, m_count}, 32'd3);
    check("lat2_idle_ready", {31'd0, m_req_ready}, 32'd1);
    @(posedge clk);
    #1;

    // Backpressure: response must hold for 5 cycles with rsp_ready low
    rsp_ready = 1'b0;
    issue(1'b0, 8'h10, 16'h0000, 16'hBEEF, 0, lat);
    held = m_rsp_rdata;
    check("bp_first_rdata", {16'd0, held}, 32'h0000BEEF);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("bp_rsp_valid_held", {31'd0, m_rsp_valid}, 32'd1);
      check("bp_rdata_held", {16'd0, m_rsp_rdata}, {16'd0, held});
      check("bp_req_ready_low", {31'd0, m_req_ready}, 32'd0);
    end
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp_idle_after_ready", {30'd0, m_state}, 32'd0);
    check("bp_rsp_valid_dropped", {31'd0, m_rsp_valid}, 32'd0);
    check("bp_count", {16'd0, m_count}, 32'd4);
    @(posedge clk);
    #1;

    // LATENCY=1 build
    sel = 1;
    issue(1'b1, 8'h01, 16'hA5A5, 16'hA5A5, 0, lat);
    check("lat1_store_latency", lat, 32'd1);
    finish_rsp();
    issue(1'b0, 8'h01, 16'h0000, 16'hA5A5, 0, lat);
    check("lat1_load_latency", lat, 32'd1);
    finish_rsp();

    // LATENCY=15 build with a stray req_valid pulse during WAIT
    sel = 2;
    issue(1'b0, 8'h07, 16'h0000, 16'h0000, 5, lat);
    check("lat15_latency", lat, 32'd15);
    finish_rsp();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("lat15_no_extra_rsp", {31'd0, m_rsp_valid}, 32'd0);
    check("lat15_count", {16'd0, m_count}, 32'd1);
    @(posedge clk);
    #1;

    // LATENCY=4 build: reset two edges after accepting a store drops it
    sel = 3;
    req_we    = 1'b1;
    req_addr  = 8'h20;
    req_wdata = 16'h1234;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midwait_reset_state", {30'd0, m_state}, 32'd0);
    check("midwait_reset_req_ready", {31'd0, m_req_ready}, 32'd1);
    check("midwait_reset_rsp_valid", {31'd0, m_rsp_valid}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    issue(1'b0, 8'h20, 16'h0000, 16'h0000, 0, lat);
    check("lat4_latency", lat, 32'd4);
    finish_rsp();
    @(negedge clk);
    check("midwait_count_after_load", {16'd0, m_count}, 32'd1);

    // Counter wrap on the LATENCY=2 build; RAM contents survived the reset
    sel = 0;
    @(posedge clk);
    #1 force g_dut[0].u_dut.access_count_q = 16'hFFFF;
    #1 release g_dut[0].u_dut.access_count_q;
    @(negedge clk);
    check("wrap_preload", {16'd0, m_count}, 32'h0000FFFF);
    @(posedge clk);
    #1;
    issue(1'b0, 8'h10, 16'h0000, 16'hBEEF, 0, lat);
    finish_rsp();
    @(negedge clk);
    check("wrap_count", {16'd0, m_count}, 32'd0);

    repeat (2) @(posedge clk);
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
